bar_motion_scheduler: RTL and testbench

- Sequences the vertical positions of the two paddle bars in the VGA pong datapath.
- Accepts new Y targets from the Nios custom instruction (clk_en/coordY), clamps them to the screen, and holds them.
- Moves each displayed bar toward its target by a bounded step, only once per frame, and only after the last visible line. The bar renderers therefore never see a Y change mid-frame.
- Outputs y_bar0/y_bar1 drive the two bar renderers directly.

---
 rtl/bar_motion_scheduler.sv | 172 +++++++++++++++++
 tb/tb_bar_motion_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bar_motion_scheduler.sv
// Paddle bar Y sequencer: clamps custom-instruction targets and walks each
// displayed bar toward its target by a bounded step once per frame, after the last visible line.
module bar_motion_scheduler #(
    parameter logic [8:0] Y_INIT    = 9'd240,
    parameter logic [8:0] Y_MIN     = 9'd0,
    parameter logic [8:0] Y_MAX     = 9'd419,
    parameter logic [7:0] MAX_STEP  = 8'd8,
    parameter logic [8:0] LAST_LINE = 9'd479
) (
    input  logic       clk_in,
    input  logic       i_rst,
    input  logic       clk_en,
    input  logic       sel,
    input  logic [8:0] coordY,
    input  logic [8:0] o_y,
    output logic       o_done,
    output logic [8:0] y_bar0,
    output logic [8:0] y_bar1,
    output logic       moving,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP0 = 2'd1,
        ST_STEP1 = 2'd2
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [8:0] o_y_q_r;
    logic       frame_tick_r;
    logic [7:0] frame_cnt_r;
    logic       o_done_r;
    logic [8:0] tgt0_r, tgt1_r;
    logic [8:0] y_bar0_r, y_bar1_r;
    logic [8:0] y_bar0_nxt_s, y_bar1_nxt_s;
    logic       step0_en_s, step1_en_s;

    // Signed compares so a zero Y_MIN does not collapse into a constant-false test.
    function automatic logic [8:0] clamp_y(input logic [8:0] v);
        logic signed [10:0] vs;
        vs = $signed({2'b00, v});
        if (vs > $signed({2'b00, Y_MAX})) begin
            clamp_y = Y_MAX;
        end else if (vs < $signed({2'b00, Y_MIN})) begin
            clamp_y = Y_MIN;
        end else begin
            clamp_y = v;
        end
    endfunction

    // Lands exactly on the target once within one step; targets are pre-clamped so the bar stays in range.
    function automatic logic [8:0] step_toward(input logic [8:0] cur, input logic [8:0] tgt);
        logic signed [9:0] d;
        logic signed [9:0] ms;
        d  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        ms = $signed({2'b00, MAX_STEP});
        if (d > ms) begin
            step_toward = cur + {1'b0, MAX_STEP};
        end else if (d < -ms) begin
            step_toward = cur - {1'b0, MAX_STEP};
        end else begin
            step_toward = tgt;
        end
    endfunction

    // State register.
    always_ff @(posedge clk_in) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a frame tick outside IDLE is ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick_r) begin
                    state_nxt_s = ST_STEP0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STEP0: state_nxt_s = ST_STEP1;
            ST_STEP1: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: which bar steps this cycle and its next position.
    always_comb begin
        step0_en_s = 1'b0;
        step1_en_s = 1'b0;
        case (state_r)
            ST_STEP0: step0_en_s = 1'b1;
            ST_STEP1: step1_en_s = 1'b1;
            default: begin
                step0_en_s = 1'b0;
                step1_en_s = 1'b0;
            end
        endcase
        if (step0_en_s) begin
            y_bar0_nxt_s = step_toward(y_bar0_r, tgt0_r);
        end else begin
            y_bar0_nxt_s = y_bar0_r;
        end
        if (step1_en_s) begin
            y_bar1_nxt_s = step_toward(y_bar1_r, tgt1_r);
        end else begin
            y_bar1_nxt_s = y_bar1_r;
        end
    end

    // Frame boundary detection and frame counter.
    always_ff @(posedge clk_in) begin
        if (!i_rst) begin
            o_y_q_r      <= 9'd0;
            frame_tick_r <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else begin
            o_y_q_r      <= o_y;
            frame_tick_r <= (o_y_q_r == LAST_LINE) && (o_y != LAST_LINE);
            if (frame_tick_r) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Request capture; the step in the same cycle still sees the old target.
    always_ff @(posedge clk_in) begin
        if (!i_rst) begin
            tgt0_r   <= Y_INIT;
            tgt1_r   <= Y_INIT;
            o_done_r <= 1'b0;
        end else begin
            o_done_r <= clk_en;
            if (clk_en && !sel) begin
                tgt0_r <= clamp_y(coordY);
            end else if (clk_en && sel) begin
                tgt1_r <= clamp_y(coordY);
            end else begin
                tgt0_r <= tgt0_r;
                tgt1_r <= tgt1_r;
            end
        end
    end

    // Displayed bar positions.
    always_ff @(posedge clk_in) begin
        if (!i_rst) begin
            y_bar0_r <= Y_INIT;
            y_bar1_r <= Y_INIT;
        end else begin
            y_bar0_r <= y_bar0_nxt_s;
            y_bar1_r <= y_bar1_nxt_s;
        end
    end

    assign o_done     = o_done_r;
    assign y_bar0     = y_bar0_r;
    assign y_bar1     = y_bar1_r;
    assign frame_tick = frame_tick_r;
    assign frame_cnt  = frame_cnt_r;
    assign moving     = (y_bar0_r != tgt0_r) || (y_bar1_r != tgt1_r);

endmodule

// File: tb/tb_bar_motion_scheduler.sv
// Directed bench for bar_motion_scheduler with a reference model feeding
// an expected-result queue that is drained after each frame.
module tb_bar_motion_scheduler;

    logic       clk_in = 1'b0;
    logic       i_rst;
    logic       clk_en;
    logic       sel;
    logic [8:0] coordY;
    logic [8:0] o_y;
    logic       o_done;
    logic [8:0] y_bar0;
    logic [8:0] y_bar1;
    logic       moving;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int y0;
        int y1;
        int cnt;
        int mv;
    } exp_t;
    exp_t sb_q[$];

    int m_tgt0, m_tgt1, m_y0, m_y1, m_cnt;

    bar_motion_scheduler dut (
        .clk_in     (clk_in),
        .i_rst      (i_rst),
        .clk_en     (clk_en),
        .sel        (sel),
        .coordY     (coordY),
        .o_y        (o_y),
        .o_done     (o_done),
        .y_bar0     (y_bar0),
        .y_bar1     (y_bar1),
        .moving     (moving),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int m_clamp(input int v);
        if (v > 419) return 419;
        if (v < 0) return 0;
        return v;
    endfunction

    function automatic int m_step(input int cur, input int tgt);
        if (tgt - cur > 8) return cur + 8;
        if (tgt - cur < -8) return cur - 8;
        return tgt;
    endfunction

    function automatic int m_moving();
        return ((m_y0 != m_tgt0) || (m_y1 != m_tgt1)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_tgt0 = 240; m_tgt1 = 240; m_y0 = 240; m_y1 = 240; m_cnt = 0;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".y_bar0"}, int'(y_bar0), e.y0);
        chk({tag, ".y_bar1"}, int'(y_bar1), e.y1);
        chk({tag, ".frame_cnt"}, int'(frame_cnt), e.cnt);
        chk({tag, ".moving"}, int'(moving), e.mv);
    endtask

    task automatic req(input logic s, input int val);
        clk_en = 1'b1;
        sel    = s;
        coordY = 9'(val);
        tick();
        clk_en = 1'b0;
        chk("done_pulse", int'(o_done), 1);
        if (s) m_tgt1 = m_clamp(val);
        else   m_tgt0 = m_clamp(val);
        chk("moving_after_req", int'(moving), m_moving());
        tick();
        chk("done_low", int'(o_done), 0);
    endtask

    // One frame boundary; optional bar0 request during STEP0, optional reset during STEP1.
    task automatic frame(input bit race, input int race_val, input bit rst_mid);
        exp_t e;
        o_y = 9'd479;
        tick();
        o_y = 9'd0;
        tick();
        chk("frame_tick", int'(frame_tick), 1);
        tick();
        if (race) begin
            clk_en = 1'b1; sel = 1'b0; coordY = 9'(race_val);
        end
        tick();
        clk_en = 1'b0;
        if (race) chk("race_done", int'(o_done), 1);
        if (rst_mid) begin
            i_rst = 1'b0;
            tick();
            i_rst = 1'b1;
            model_reset();
        end else begin
            tick();
            m_y0 = m_step(m_y0, m_tgt0);
            m_y1 = m_step(m_y1, m_tgt1);
            m_cnt = (m_cnt + 1) % 256;
            if (race) m_tgt0 = m_clamp(race_val);
        end
        e.y0 = m_y0; e.y1 = m_y1; e.cnt = m_cnt; e.mv = m_moving();
        sb_q.push_back(e);
        chk("frame_tick_one_wide", int'(frame_tick), 0);
        check_state("frame", sb_q.pop_front());
    endtask

    initial begin
        exp_t e;
        i_rst = 1'b0; clk_en = 1'b0; sel = 1'b0; coordY = 9'd0; o_y = 9'd0;
        model_reset();
        repeat (3) tick();
        i_rst = 1'b1;
        e.y0 = 240; e.y1 = 240; e.cnt = 0; e.mv = 0;
        sb_q.push_back(e);
        check_state("reset", sb_q.pop_front());
        chk("reset.o_done", int'(o_done), 0);
        chk("reset.frame_tick", int'(frame_tick), 0);

        // Clamp high, then low, then park bar0 back at 240.
        req(1'b0, 500);
        frame(1'b0, 0, 1'b0);
        req(1'b0, 0);
        frame(1'b0, 0, 1'b0);
        req(1'b0, 240);

        // Bounded stepping of bar1; first frame uses a full line sweep.
        req(1'b1, 300);
        for (int y = 0; y < 479; y++) begin
            o_y = 9'(y);
            tick();
            chk("sweep_no_tick", int'(frame_tick), 0);
        end
        frame(1'b0, 0, 1'b0);
        for (int i = 0; i < 9; i++) frame(1'b0, 0, 1'b0);

        // Mid-frame request must not move the bar until the frame boundary.
        o_y = 9'd200;
        tick();
        req(1'b0, 100);
        for (int y = 201; y < 206; y++) begin
            o_y = 9'(y);
            tick();
        end
        chk("midframe_hold", int'(y_bar0), 240);
        frame(1'b0, 0, 1'b0);

        // Request landing in STEP0 uses the old target this frame.
        frame(1'b1, 400, 1'b0);
        frame(1'b0, 0, 1'b0);

        // Reset during STEP1 discards the step.
        req(1'b1, 50);
        frame(1'b0, 0, 1'b1);
        chk("rst_mid.o_done", int'(o_done), 0);

        // Counter wrap over 256 frames.
        for (int i = 0; i < 256; i++) frame(1'b0, 0, 1'b0);
        chk("wrap_cnt", int'(frame_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
